mcu_mem_bus_arbiter: RTL and testbench
======================================

// Module: mcu_mem_bus_arbiter
// PURPOSE
// Shares the DDR controller user interface between three requesters: L1 data segment cache (dsc),
// program segment cache (psc) and the L2 cache. Sits in mcu_top, clk_166M66 domain, between the caches and ddr3_with_controller.
// Issues one BURST_LENTH-beat DDR command per grant; fixed priority dsc > psc > l2.
// After any transfer it enforces a GAP_CYCLES idle gap before the next grant if a request was waiting.
// PARAMETERS
// BURST_LENTH   8    data beats per grant
// ADDR_WIDTH    28   DDR user address width
// GAP_CYCLES    4    idle cycles between back-to-back grants
// PORTS
// clk_166M66           in   1           system clock
// mcu_sys_rst_n        in   1           async active-low reset
// i_ddr_ready          in   1           DDR calibration complete
// i_dsc_request        in   1           dsc wants bus; held until o_dsc_bus_available
// i_dsc_rw             in   1           1=write, 0=read
// i_dsc_addr           in   ADDR_WIDTH  burst start address
// o_dsc_bus_available  out  1           dsc owns bus (grant)
// i_psc_request/i_psc_rw/i_psc_addr, o_psc_bus_available   same as dsc
// i_l2_request/i_l2_rw/i_l2_addr, o_l2_bus_available       same as dsc
// o_ddr_op_en          out  1           command valid to DDR controller
// o_ddr_op_cmd         out  3           3'b000 write, 3'b001 read
// o_ddr_op_addr        out  ADDR_WIDTH  latched address of granted requester
// i_ddr_cmd_rdy        in   1           controller accepts command when op_en & cmd_rdy
// i_ddr_beat           in   1           one data beat transferred (rd valid or wr accepted)
// o_grant_id           out  2           0 none, 1 dsc, 2 psc, 3 l2 (data-bus mux select)
// o_busy               out  1           state != IDLE
// BEHAVIOUR
// Reset: all outputs 0, state IDLE, beat and gap counters 0; async reset mid-burst aborts at once.
// All outputs registered. States: IDLE, CMD, XFER, GAP.
// IDLE: if i_ddr_ready and any request -> pick by priority dsc>psc>l2, latch addr/rw/id; next cycle
//   state CMD, o_ddr_op_en=1, matching o_*_bus_available=1, o_grant_id set (grant latency 1 clk).
// CMD: hold op_en/cmd/addr stable until op_en & i_ddr_cmd_rdy; that cycle op_en drops next clk -> XFER.
// Beats counted in CMD and XFER (write data may precede cmd acceptance); counter width clog2(BURST_LENTH+1).
// XFER: on beat number BURST_LENTH: drop bus_available and grant_id next clk;
//   if any request asserted that cycle -> GAP, else -> IDLE.
// GAP: count GAP_CYCLES clocks with no grant, then re-arbitrate (same priority) and grant directly
//   into CMD; if requests vanished -> IDLE. Priority sampled at arbitration cycle only.
// Request deassert after grant ignored; burst completes. Requests of non-granted units held off (no queue).
// Simultaneous requests in IDLE: highest priority wins; others wait, served after gap.
// i_ddr_ready low in any state: sync return to IDLE next clk, all grants/op_en cleared, counters 0.
// i_ddr_beat in IDLE/GAP ignored; beats beyond BURST_LENTH impossible (state leaves XFER).
// Fixed priority: l2 may starve under continuous dsc/psc traffic; accepted by design.
// STRUCTURE
// mcu_pkg: state encoding, grant-id constants (GID_NONE/DSC/PSC/L2), DDR cmd codes (CMD_WR/CMD_RD).
// Sub-module mcu_arb_prio_enc: combinational 3-in fixed-priority encoder -> grant id.
// Top: FSM, address/rw latch, beat counter, gap counter, output registers.
// TESTING
// Single l2 read req addr 0x0000100, cmd_rdy=1 -> l2 grant + op_en cmd 3'b001 one clk later, 8 beats, release.
// dsc & l2 req same cycle -> dsc granted first; l2 granted exactly 4 idle clks after dsc burst ends.
// psc req mid dsc burst (beat 3) -> psc grant only after dsc beat 8 plus 4 gap clks.
// cmd_rdy held low 5 clks -> op_en/addr/cmd stable all 5; XFER entered only after acceptance.
// Reset asserted at beat 4 -> all outputs 0 immediately; after release, pending dsc granted from IDLE.
// i_ddr_ready low at reset exit with l2 req -> no grant; ready high -> grant 1 clk later; ready drop mid-XFER -> IDLE.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared types and constants for the memory bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, grant-id codes, DDR command codes,
// and small decode helpers used by the arbiter top.
package mcu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_XFER = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam logic [1:0] GID_NONE = 2'd0;
  localparam logic [1:0] GID_DSC  = 2'd1;
  localparam logic [1:0] GID_PSC  = 2'd2;
  localparam logic [1:0] GID_L2   = 2'd3;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  // Grant id -> {l2, psc, dsc} bus_available vector.
  function automatic logic [2:0] gid_onehot(input logic [1:0] gid);
    case (gid)
      GID_DSC: return 3'b001;
      GID_PSC: return 3'b010;
      GID_L2:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] rw_to_cmd(input logic rw);
    return rw ? CMD_WR : CMD_RD;
  endfunction

endpackage

// File: rtl/mcu_arb_prio_enc.sv
// Fixed-priority encoder: dsc > psc > l2, returns the winner's grant id.
// Latency: combinational.
// Backpressure: none; losers are simply not selected.
// Ports: req_i {l2, psc, dsc} request vector; gid_o winning grant id (GID_NONE if idle).
module mcu_arb_prio_enc
  import mcu_pkg::*;
(
  input  logic [2:0] req_i,
  output logic [1:0] gid_o
);

  always_comb begin
    gid_o = GID_NONE;
    if (req_i[0])      gid_o = GID_DSC;
    else if (req_i[1]) gid_o = GID_PSC;
    else if (req_i[2]) gid_o = GID_L2;
  end

endmodule

// File: rtl/mcu_mem_bus_arbiter.sv
// Shares the DDR user interface between dsc, psc and l2; one BURST_LENTH-beat command per grant.
// Latency: grant + op_en one clock after arbitration; GAP_CYCLES idle clocks between back-to-back grants.
// Backpressure: command held until cmd_rdy; other requesters held off (no queue) until the burst and gap end.
// Ports: per-requester request/rw/addr in, bus_available out; DDR op_en/cmd/addr out,
// cmd_rdy/beat/ready in; grant_id (data mux select) and busy out. All outputs registered.
module mcu_mem_bus_arbiter
  import mcu_pkg::*;
#(
  parameter int BURST_LENTH = 8,
  parameter int ADDR_WIDTH  = 28,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                  clk_166M66,
  input  logic                  mcu_sys_rst_n,
  input  logic                  i_ddr_ready,
  input  logic                  i_dsc_request,
  input  logic                  i_dsc_rw,
  input  logic [ADDR_WIDTH-1:0] i_dsc_addr,
  output logic                  o_dsc_bus_available,
  input  logic                  i_psc_request,
  input  logic                  i_psc_rw,
  input  logic [ADDR_WIDTH-1:0] i_psc_addr,
  output logic                  o_psc_bus_available,
  input  logic                  i_l2_request,
  input  logic                  i_l2_rw,
  input  logic [ADDR_WIDTH-1:0] i_l2_addr,
  output logic                  o_l2_bus_available,
  output logic                  o_ddr_op_en,
  output logic [2:0]            o_ddr_op_cmd,
  output logic [ADDR_WIDTH-1:0] o_ddr_op_addr,
  input  logic                  i_ddr_cmd_rdy,
  input  logic                  i_ddr_beat,
  output logic [1:0]            o_grant_id,
  output logic                  o_busy
);

  localparam int BW = $clog2(BURST_LENTH + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW:0]   BEATS_ALL = (BW + 1)'(BURST_LENTH);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  state_e                state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [1:0]            gid_q, gid_d;
  logic                  op_en_q, op_en_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            avail_q;
  logic                  busy_q;

  logic [2:0]            req_vec;
  logic                  any_req;
  logic [1:0]            win_gid;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  win_rw;
  logic [BW:0]           beat_sum;
  logic                  grant_now;

  assign req_vec = {i_l2_request, i_psc_request, i_dsc_request};
  assign any_req = |req_vec;

  mcu_arb_prio_enc u_prio_enc (
    .req_i (req_vec),
    .gid_o (win_gid)
  );

  always_comb begin
    win_addr = i_l2_addr;
    win_rw   = i_l2_rw;
    case (win_gid)
      GID_DSC: begin win_addr = i_dsc_addr; win_rw = i_dsc_rw; end
      GID_PSC: begin win_addr = i_psc_addr; win_rw = i_psc_rw; end
      default: ;
    endcase
  end

  // One extra bit so the sum cannot wrap when the count is already at BURST_LENTH.
  assign beat_sum = {1'b0, beat_q} + (BW + 1)'(i_ddr_beat);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    gap_d     = gap_q;
    gid_d     = gid_q;
    op_en_d   = op_en_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    grant_now = 1'b0;

    if (!i_ddr_ready) begin
      // Controller lost calibration: drop everything and wait in IDLE.
      state_d = ST_IDLE;
      gid_d   = GID_NONE;
      op_en_d = 1'b0;
      beat_d  = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: grant_now = any_req;
        ST_CMD: begin
          // Write data may run ahead of command acceptance; count it, saturating at a full burst.
          if (beat_sum <= BEATS_ALL) beat_d = beat_sum[BW-1:0];
          if (op_en_q && i_ddr_cmd_rdy) begin
            op_en_d = 1'b0;
            state_d = ST_XFER;
          end
        end
        ST_XFER: begin
          if (beat_sum >= BEATS_ALL) begin
            gid_d   = GID_NONE;
            beat_d  = '0;
            gap_d   = '0;
            state_d = any_req ? ST_GAP : ST_IDLE;
          end else begin
            beat_d = beat_sum[BW-1:0];
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_d     = '0;
            grant_now = any_req;
            if (!any_req) state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (grant_now) begin
      state_d = ST_CMD;
      gid_d   = win_gid;
      op_en_d = 1'b1;
      addr_d  = win_addr;
      cmd_d   = rw_to_cmd(win_rw);
      beat_d  = '0;
    end
  end

  always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
    if (!mcu_sys_rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      gap_q   <= '0;
      gid_q   <= GID_NONE;
      op_en_q <= 1'b0;
      cmd_q   <= 3'b000;
      addr_q  <= '0;
      avail_q <= 3'b000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      gid_q   <= gid_d;
      op_en_q <= op_en_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      avail_q <= gid_onehot(gid_d);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign o_dsc_bus_available = avail_q[0];
  assign o_psc_bus_available = avail_q[1];
  assign o_l2_bus_available  = avail_q[2];
  assign o_ddr_op_en         = op_en_q;
  assign o_ddr_op_cmd        = cmd_q;
  assign o_ddr_op_addr       = addr_q;
  assign o_grant_id          = gid_q;
  assign o_busy              = busy_q;

endmodule

// File: tb/tb_mcu_mem_bus_arbiter.sv
// Testbench for mcu_mem_bus_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level ownership/timestamp model.
module tb_mcu_mem_bus_arbiter;

  localparam int AW    = 28;
  localparam int BURST = 8;
  localparam int GAP   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ready;
  logic [2:0]    req;
  logic [2:0]    rw;
  logic [AW-1:0] addr [3];
  logic          cmd_rdy;
  logic          beat;

  logic          dsc_av, psc_av, l2_av;
  logic          op_en;
  logic [2:0]    op_cmd;
  logic [AW-1:0] op_addr;
  logic [1:0]    gid;
  logic          busy;
  logic [2:0]    avail;

  int n_vec  = 0;
  int n_fail = 0;

  always #3 clk = ~clk;
  assign avail = {l2_av, psc_av, dsc_av};

  mcu_mem_bus_arbiter dut (
    .clk_166M66          (clk),
    .mcu_sys_rst_n       (rst_n),
    .i_ddr_ready         (ready),
    .i_dsc_request       (req[0]),
    .i_dsc_rw            (rw[0]),
    .i_dsc_addr          (addr[0]),
    .o_dsc_bus_available (dsc_av),
    .i_psc_request       (req[1]),
    .i_psc_rw            (rw[1]),
    .i_psc_addr          (addr[1]),
    .o_psc_bus_available (psc_av),
    .i_l2_request        (req[2]),
    .i_l2_rw             (rw[2]),
    .i_l2_addr           (addr[2]),
    .o_l2_bus_available  (l2_av),
    .o_ddr_op_en         (op_en),
    .o_ddr_op_cmd        (op_cmd),
    .o_ddr_op_addr       (op_addr),
    .i_ddr_cmd_rdy       (cmd_rdy),
    .i_ddr_beat          (beat),
    .o_grant_id          (gid),
    .o_busy              (busy)
  );

  // Stimulus only: deliver n beats with random bubbles, return at the negedge after the last one.
  task automatic drive_beats(input int n);
    int sent = 0;
    while (sent < n) begin
      beat = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (beat) sent++;
    end
    beat = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ready = 1'b0; req = '0; rw = '0; cmd_rdy = 1'b0; beat = 1'b0;
    for (int i = 0; i < 3; i++) addr[i] = '0;
    #5;
    n_vec++; if (gid !== 2'd0) begin n_fail++; $display("FAIL reset_gid got %0d want 0", gid); end
    n_vec++; if (avail !== 3'b000) begin n_fail++; $display("FAIL reset_avail got %b want 000", avail); end
    n_vec++; if (op_en !== 1'b0) begin n_fail++; $display("FAIL reset_op_en got %b want 0", op_en); end
    n_vec++; if (op_cmd !== 3'b000) begin n_fail++; $display("FAIL reset_cmd got %b want 000", op_cmd); end
    n_vec++; if (op_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 0", op_addr); end
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1; ready = 1'b1;
  endtask

  task automatic test_single_l2_read();
    @(negedge clk);
    req[2] = 1'b1; rw[2] = 1'b0; addr[2] = 28'h0000100; cmd_rdy = 1'b1;
    @(negedge clk);
    n_vec++; if ({gid, avail, op_en, busy} !== {2'd3, 3'b100, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL l2_grant got gid=%0d av=%b en=%b busy=%b want 3/100/1/1", gid, avail, op_en, busy); end
    n_vec++; if ({op_cmd, op_addr} !== {3'b001, 28'h0000100}) begin
      n_fail++; $display("FAIL l2_cmd got cmd=%b addr=%h want 001/0000100", op_cmd, op_addr); end
    req[2] = 1'b0;
    @(negedge clk);
    cmd_rdy = 1'b0;
    n_vec++; if ({op_en, avail} !== 4'b0100) begin
      n_fail++; $display("FAIL l2_accept got en=%b av=%b want 0/100", op_en, avail); end
    for (int b = 1; b <= BURST; b++) begin
      beat = 1'b1;
      @(negedge clk);
      beat = 1'b0;
      n_vec++; if (avail !== ((b < BURST) ? 3'b100 : 3'b000)) begin
        n_fail++; $display("FAIL l2_beat%0d got av=%b", b, avail); end
      if (b < BURST && $urandom_range(0, 1) == 1) @(negedge clk);
    end
    n_vec++; if ({gid, busy} !== 3'b000) begin
      n_fail++; $display("FAIL l2_release got gid=%0d busy=%b want 0/0", gid, busy); end
  endtask

  task automatic test_simultaneous();
    int idle;
    logic [2:0] exp_cmd;
    @(negedge clk);
    req[0] = 1'b1; rw[0] = 1'($urandom); addr[0] = AW'($urandom);
    req[2] = 1'b1; rw[2] = 1'($urandom); addr[2] = AW'($urandom);
    cmd_rdy = 1'b1;
    @(negedge clk);
    exp_cmd = rw[0] ? 3'b000 : 3'b001;
    n_vec++; if ({gid, op_cmd, op_addr} !== {2'd1, exp_cmd, addr[0]}) begin
      n_fail++; $display("FAIL simul_first got gid=%0d cmd=%b addr=%h want 1/%b/%h", gid, op_cmd, op_addr, exp_cmd, addr[0]); end
    req[0] = 1'b0;
    @(negedge clk);
    cmd_rdy = 1'b0;
    drive_beats(BURST);
    n_vec++; if ({gid, busy} !== {2'd0, 1'b1}) begin
      n_fail++; $display("FAIL simul_gap_entry got gid=%0d busy=%b want 0/1", gid, busy); end
    idle = 1;
    for (int k = 0; k < 20 && gid == 2'd0; k++) begin
      @(negedge clk);
      if (gid == 2'd0) idle++;
    end
    exp_cmd = rw[2] ? 3'b000 : 3'b001;
    n_vec++; if (idle !== GAP) begin n_fail++; $display("FAIL simul_gap_len got %0d want %0d", idle, GAP); end
    n_vec++; if ({gid, op_en, op_cmd, op_addr} !== {2'd3, 1'b1, exp_cmd, addr[2]}) begin
      n_fail++; $display("FAIL simul_second got gid=%0d en=%b cmd=%b addr=%h", gid, op_en, op_cmd, op_addr); end
    req[2] = 1'b0; cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
    drive_beats(BURST);
    n_vec++; if ({gid, busy} !== 3'b000) begin
      n_fail++; $display("FAIL simul_end got gid=%0d busy=%b want 0/0", gid, busy); end
  endtask

  task automatic test_mid_burst_req();
    int idle;
    @(negedge clk);
    req[0] = 1'b1; rw[0] = 1'b0; addr[0] = AW'($urandom); cmd_rdy = 1'b1;
    @(negedge clk);
    n_vec++; if (gid !== 2'd1) begin n_fail++; $display("FAIL mid_dsc_grant got %0d want 1", gid); end
    req[0] = 1'b0;
    @(negedge clk);
    cmd_rdy = 1'b0;
    drive_beats(3);
    req[1] = 1'b1; rw[1] = 1'($urandom); addr[1] = AW'($urandom);
    drive_beats(4);
    n_vec++; if ({gid, avail} !== {2'd1, 3'b001}) begin
      n_fail++; $display("FAIL mid_no_preempt got gid=%0d av=%b want 1/001", gid, avail); end
    drive_beats(1);
    idle = 1;
    for (int k = 0; k < 20 && gid == 2'd0; k++) begin
      @(negedge clk);
      if (gid == 2'd0) idle++;
    end
    n_vec++; if (idle !== GAP) begin n_fail++; $display("FAIL mid_gap_len got %0d want %0d", idle, GAP); end
    n_vec++; if ({gid, avail, op_addr} !== {2'd2, 3'b010, addr[1]}) begin
      n_fail++; $display("FAIL mid_psc_grant got gid=%0d av=%b addr=%h", gid, avail, op_addr); end
    req[1] = 1'b0; cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
    drive_beats(BURST);
  endtask

  task automatic test_cmd_stall();
    logic [AW-1:0] a;
    @(negedge clk);
    a = AW'($urandom);
    req[0] = 1'b1; rw[0] = 1'b1; addr[0] = a; cmd_rdy = 1'b0;
    @(negedge clk);
    n_vec++; if (gid !== 2'd1) begin n_fail++; $display("FAIL stall_grant got %0d want 1", gid); end
    req[0] = 1'b0; addr[0] = ~a;
    // Two write beats run ahead of command acceptance.
    for (int k = 1; k <= 5; k++) begin
      beat = (k <= 2);
      @(negedge clk);
      n_vec++; if ({op_en, op_cmd, op_addr} !== {1'b1, 3'b000, a}) begin
        n_fail++; $display("FAIL stall_hold%0d got en=%b cmd=%b addr=%h want 1/000/%h", k, op_en, op_cmd, op_addr, a); end
    end
    beat = 1'b0; cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
    n_vec++; if ({op_en, avail} !== 4'b0001) begin
      n_fail++; $display("FAIL stall_accept got en=%b av=%b want 0/001", op_en, avail); end
    for (int b = 1; b <= BURST - 2; b++) begin
      beat = 1'b1;
      @(negedge clk);
      beat = 1'b0;
      n_vec++; if (avail !== ((b < BURST - 2) ? 3'b001 : 3'b000)) begin
        n_fail++; $display("FAIL stall_beat%0d got av=%b", b, avail); end
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    req[0] = 1'b1; rw[0] = 1'b0; addr[0] = AW'($urandom); cmd_rdy = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    cmd_rdy = 1'b0;
    drive_beats(4);
    req[0] = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if ({gid, avail, op_en, busy, op_cmd, op_addr} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs got gid=%0d av=%b en=%b busy=%b cmd=%b addr=%h want all 0",
                         gid, avail, op_en, busy, op_cmd, op_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if ({gid, avail, op_en} !== {2'd1, 3'b001, 1'b1}) begin
      n_fail++; $display("FAIL rst_mid_regrant got gid=%0d av=%b en=%b want 1/001/1", gid, avail, op_en); end
    req[0] = 1'b0; cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
    drive_beats(BURST);
  endtask

  task automatic test_ddr_ready();
    rst_n = 1'b0; ready = 1'b0; req = 3'b100; rw[2] = 1'b0; addr[2] = AW'($urandom);
    #4;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++; if ({gid, busy} !== 3'b000) begin
        n_fail++; $display("FAIL rdy_low_hold%0d got gid=%0d busy=%b want 0/0", k, gid, busy); end
    end
    ready = 1'b1;
    @(negedge clk);
    n_vec++; if (gid !== 2'd3) begin n_fail++; $display("FAIL rdy_grant got %0d want 3", gid); end
    req[2] = 1'b0; cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
    drive_beats(3);
    ready = 1'b0;
    @(negedge clk);
    n_vec++; if ({gid, avail, op_en, busy} !== '0) begin
      n_fail++; $display("FAIL rdy_drop got gid=%0d av=%b en=%b busy=%b want all 0", gid, avail, op_en, busy); end
    ready = 1'b1; req[2] = 1'b1;
    @(negedge clk);
    req[2] = 1'b0; cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
    // A fresh burst must need a full count of beats after the abort.
    drive_beats(BURST - 1);
    n_vec++; if (avail !== 3'b100) begin n_fail++; $display("FAIL rdy_fresh_count got av=%b want 100", avail); end
    drive_beats(1);
    n_vec++; if (avail !== 3'b000) begin n_fail++; $display("FAIL rdy_fresh_end got av=%b want 000", avail); end
  endtask

  // Random traffic vs. an ownership model: who owns the bus, whether the command was taken,
  // beats delivered, and the cycle at which the next arbitration is allowed after a gap.
  task automatic test_random();
    int m_own, m_beats, m_now, m_arb_at;
    bit m_acc, m_gap, any;
    logic [2:0] m_cmd, exp_av;
    logic [AW-1:0] m_addr;
    m_own = 0; m_beats = 0; m_now = 0; m_arb_at = 0; m_acc = 0; m_gap = 0;
    m_cmd = '0; m_addr = '0;
    rst_n = 1'b0; ready = 1'b1; req = '0; cmd_rdy = 1'b0; beat = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      m_now++;
      any = |req;
      if (!ready) begin
        m_own = 0; m_acc = 0; m_beats = 0; m_gap = 0;
      end else if (m_own == 0) begin
        if (!m_gap || m_now >= m_arb_at) begin
          m_gap = 0;
          if (any) begin
            m_own   = req[0] ? 1 : (req[1] ? 2 : 3);
            m_acc   = 0;
            m_beats = 0;
            m_addr  = addr[m_own-1];
            m_cmd   = rw[m_own-1] ? 3'b000 : 3'b001;
          end
        end
      end else if (!m_acc) begin
        m_beats = (m_beats + int'(beat) > BURST) ? BURST : m_beats + int'(beat);
        if (cmd_rdy) m_acc = 1;
      end else if (m_beats + int'(beat) >= BURST) begin
        m_own = 0; m_gap = any; m_arb_at = m_now + GAP;
      end else begin
        m_beats += int'(beat);
      end

      exp_av = (m_own == 0) ? 3'b000 : (3'b001 << (m_own - 1));
      n_vec++;
      if ({gid, avail, op_en, busy} !== {2'(m_own), exp_av, (m_own != 0 && !m_acc), (m_own != 0 || m_gap)}) begin
        n_fail++;
        $display("FAIL rand_state cyc=%0d got gid=%0d av=%b en=%b busy=%b want %0d/%b/%b/%b", c, gid, avail,
                 op_en, busy, m_own, exp_av, (m_own != 0 && !m_acc), (m_own != 0 || m_gap));
      end
      if (m_own != 0 && !m_acc) begin
        n_vec++;
        if ({op_cmd, op_addr} !== {m_cmd, m_addr}) begin
          n_fail++;
          $display("FAIL rand_cmd cyc=%0d got cmd=%b addr=%h want %b/%h", c, op_cmd, op_addr, m_cmd, m_addr);
        end
      end

      for (int r = 0; r < 3; r++) begin
        if (req[r]) begin
          if (avail[r] && $urandom_range(0, 1) == 1) req[r] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          req[r] = 1'b1; rw[r] = 1'($urandom); addr[r] = AW'($urandom);
        end
      end
      ready   = ($urandom_range(0, 99) != 0);
      cmd_rdy = 1'($urandom);
      beat    = 1'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_single_l2_read();
    test_simultaneous();
    test_mid_burst_req();
    test_cmd_stall();
    test_reset_mid_burst();
    test_ddr_ready();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
